data_buffer_ctrl: RTL and testbench

//  Sequences ownership of the 64-byte endpoint data buffer (data_buffer) between USB RX (host OUT data),
//  the AHB-Lite slave (reads of RX data / writes of TX data) and USB TX (host IN data).

---
 rtl/data_buffer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_data_buffer_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_buffer_ctrl.sv
// data_buffer_ctrl: hands the 64-byte endpoint buffer between USB RX, AHB and USB TX.
// It drives every data_buffer strobe and rejects transfers that would overrun or underrun the buffer.
module data_buffer_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned OCC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_packet_start,
  input  logic             rx_byte_valid,
  input  logic             rx_packet_done,
  input  logic             rx_packet_err,
  input  logic             ahb_rd_req,
  input  logic             ahb_wr_req,
  input  logic [1:0]       ahb_size,
  input  logic             ahb_flush,
  input  logic             tx_packet_start,
  input  logic             tx_byte_req,
  input  logic [OCC_W-1:0] buffer_occupancy,
  output logic             store_rx_packet_data,
  output logic             get_rx_data,
  output logic             store_tx_data,
  output logic             get_tx_packet_data,
  output logic             clear,
  output logic             buffer_reserved,
  output logic             ahb_ack,
  output logic             ahb_err,
  output logic             rx_overflow,
  output logic             rx_busy
);

  localparam int unsigned SUM_W = OCC_W + 1;

  typedef enum logic [2:0] {IDLE, RX, HOLD, AHB_WR, TX} state_t;

  state_t           state, state_next;
  logic             store_rx_d, get_rx_d, store_tx_d, get_tx_d, clear_d, ack_d, err_d, overflow_d;
  logic [SUM_W-1:0] occ, rx_fill, req_bytes, depth;
  logic             rd_req, wr_req;

  assign occ       = SUM_W'(buffer_occupancy);
  // last cycle's RX store has not reached buffer_occupancy yet
  assign rx_fill   = occ + SUM_W'(store_rx_packet_data);
  assign req_bytes = SUM_W'(ahb_size) + SUM_W'(1);
  assign depth     = SUM_W'(DEPTH);
  // a held request is ignored while its previous response is still being absorbed
  assign rd_req    = ahb_rd_req && !ahb_ack && !ahb_err;
  assign wr_req    = ahb_wr_req && !ahb_ack && !ahb_err;

  // next-state and strobe decode
  always_comb begin
    state_next = state;
    store_rx_d = 1'b0;
    get_rx_d   = 1'b0;
    store_tx_d = 1'b0;
    get_tx_d   = 1'b0;
    clear_d    = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    overflow_d = rx_overflow;

    if (ahb_flush) begin
      state_next = IDLE;
      clear_d    = 1'b1;
      overflow_d = 1'b0;
    end else begin
      if (rx_packet_start) overflow_d = 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_packet_start && occ == '0) begin
            state_next = RX;
          end else if (wr_req) begin
            if (occ + req_bytes <= depth) begin
              store_tx_d = 1'b1;
              ack_d      = 1'b1;
              state_next = AHB_WR;
            end else begin
              err_d = 1'b1;
            end
          end else if (rd_req) begin
            err_d = 1'b1;
          end
        end
        RX: begin
          if (rx_packet_err) begin
            clear_d    = 1'b1;
            state_next = IDLE;
          end else begin
            if (rx_byte_valid) begin
              if (rx_fill < depth) store_rx_d = 1'b1;
              else                 overflow_d = 1'b1;
            end
            if (rx_packet_done)
              state_next = ((rx_fill + SUM_W'(store_rx_d)) != '0) ? HOLD : IDLE;
          end
          if (rd_req || wr_req) err_d = 1'b1;
        end
        HOLD: begin
          if (rd_req) begin
            if (occ >= req_bytes) begin
              get_rx_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (wr_req) begin
            err_d = 1'b1;
          end
          if (occ == '0 && !get_rx_data) state_next = IDLE;
        end
        AHB_WR: begin
          if (wr_req) begin
            if (occ + req_bytes <= depth) begin
              store_tx_d = 1'b1;
              ack_d      = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (rd_req) begin
            err_d = 1'b1;
          end
          if (tx_packet_start) state_next = TX;
        end
        TX: begin
          // discount a fetch already issued but not yet seen in occupancy
          if (tx_byte_req && occ > SUM_W'(get_tx_packet_data)) get_tx_d = 1'b1;
          if (rd_req || wr_req) err_d = 1'b1;
          if (occ == '0 && !get_tx_packet_data) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      store_rx_packet_data <= 1'b0;
      get_rx_data          <= 1'b0;
      store_tx_data        <= 1'b0;
      get_tx_packet_data   <= 1'b0;
      clear                <= 1'b0;
      buffer_reserved      <= 1'b0;
      ahb_ack              <= 1'b0;
      ahb_err              <= 1'b0;
      rx_overflow          <= 1'b0;
      rx_busy              <= 1'b0;
    end else begin
      state                <= state_next;
      store_rx_packet_data <= store_rx_d;
      get_rx_data          <= get_rx_d;
      store_tx_data        <= store_tx_d;
      get_tx_packet_data   <= get_tx_d;
      clear                <= clear_d;
      buffer_reserved      <= (state_next == AHB_WR) || (state_next == TX);
      ahb_ack              <= ack_d;
      ahb_err              <= err_d;
      rx_overflow          <= overflow_d;
      rx_busy              <= (state_next == HOLD);
    end
  end

endmodule

// File: tb/tb_data_buffer_ctrl.sv
// Testbench for data_buffer_ctrl: random RX/AHB/TX transactions against a byte-count ownership model,
// with a scoreboard of expected strobe events drained by an output monitor.
`timescale 1ns/1ps
module tb_data_buffer_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned OCC_W = 7;

  localparam logic [6:0] E_STORE_RX = 7'h01;
  localparam logic [6:0] E_GET_RX   = 7'h02;
  localparam logic [6:0] E_STORE_TX = 7'h04;
  localparam logic [6:0] E_GET_TX   = 7'h08;
  localparam logic [6:0] E_CLEAR    = 7'h10;
  localparam logic [6:0] E_ACK      = 7'h20;
  localparam logic [6:0] E_ERR      = 7'h40;

  localparam int M_FREE = 0;
  localparam int M_HELD = 1;
  localparam int M_WR   = 2;
  localparam int M_TX   = 3;

  logic clk = 1'b0;
  logic rst;
  logic rx_packet_start, rx_byte_valid, rx_packet_done, rx_packet_err;
  logic ahb_rd_req, ahb_wr_req, ahb_flush, tx_packet_start, tx_byte_req;
  logic [1:0] ahb_size;
  logic [OCC_W-1:0] buffer_occupancy;
  logic store_rx_packet_data, get_rx_data, store_tx_data, get_tx_packet_data, clear;
  logic buffer_reserved, ahb_ack, ahb_err, rx_overflow, rx_busy;

  int compared = 0;
  int mismatched = 0;
  logic [6:0] exp_q[$];
  int m_occ;
  int m_mode;
  bit m_ovf;

  always #5 clk = ~clk;

  data_buffer_ctrl #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
    .clk(clk), .rst(rst),
    .rx_packet_start(rx_packet_start), .rx_byte_valid(rx_byte_valid),
    .rx_packet_done(rx_packet_done), .rx_packet_err(rx_packet_err),
    .ahb_rd_req(ahb_rd_req), .ahb_wr_req(ahb_wr_req), .ahb_size(ahb_size),
    .ahb_flush(ahb_flush), .tx_packet_start(tx_packet_start), .tx_byte_req(tx_byte_req),
    .buffer_occupancy(buffer_occupancy),
    .store_rx_packet_data(store_rx_packet_data), .get_rx_data(get_rx_data),
    .store_tx_data(store_tx_data), .get_tx_packet_data(get_tx_packet_data),
    .clear(clear), .buffer_reserved(buffer_reserved), .ahb_ack(ahb_ack),
    .ahb_err(ahb_err), .rx_overflow(rx_overflow), .rx_busy(rx_busy)
  );

  // stand-in for data_buffer's occupancy counter
  always @(posedge clk) begin
    if (rst || clear)
      buffer_occupancy <= '0;
    else
      buffer_occupancy <= buffer_occupancy
                          + OCC_W'(store_rx_packet_data)
                          + (store_tx_data ? OCC_W'(ahb_size) + OCC_W'(1) : OCC_W'(0))
                          - OCC_W'(get_tx_packet_data)
                          - (get_rx_data ? OCC_W'(ahb_size) + OCC_W'(1) : OCC_W'(0));
  end

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // scoreboard monitor: every strobe/response cycle consumes one expected event
  always @(negedge clk) begin
    logic [6:0] ev;
    logic [6:0] e;
    ev = {ahb_err, ahb_ack, clear, get_tx_packet_data, store_tx_data, get_rx_data, store_rx_packet_data};
    if (!rst && ev != 7'h00) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL strobe_event: got %b, required none", ev);
      end else begin
        e = exp_q.pop_front();
        if (ev != e) begin
          mismatched++;
          $display("FAIL strobe_event: got %b, required %b", ev, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({store_rx_packet_data, get_rx_data, store_tx_data, get_tx_packet_data, clear,
                      buffer_reserved, ahb_ack, ahb_err, rx_overflow, rx_busy}), 0);
  endtask

  task automatic rx_packet(input int n, input bit merge_done, input bit good);
    int space;
    rx_packet_start = 1'b1; tick(); rx_packet_start = 1'b0;
    m_ovf = 1'b0;
    space = DEPTH - m_occ;
    for (int i = 0; i < n; i++) begin
      rx_byte_valid = 1'b1;
      if (i < space) begin
        exp_q.push_back(E_STORE_RX);
        m_occ++;
      end else begin
        m_ovf = 1'b1;
      end
      if (good && merge_done && i == n - 1) rx_packet_done = 1'b1;
      tick();
      rx_byte_valid = 1'b0;
      rx_packet_done = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    if (good) begin
      if (!(merge_done && n > 0)) begin
        rx_packet_done = 1'b1; tick(); rx_packet_done = 1'b0;
      end
      m_mode = (m_occ > 0) ? M_HELD : M_FREE;
    end else begin
      rx_packet_err = 1'b1;
      exp_q.push_back(E_CLEAR);
      tick();
      rx_packet_err = 1'b0;
      m_occ = 0;
      m_mode = M_FREE;
    end
    repeat (3) tick();
  endtask

  task automatic ahb_req(input bit wr, input int size, output bit ok);
    int k;
    bit seen;
    if (wr) begin
      ok = (m_mode == M_FREE || m_mode == M_WR) && (m_occ + size + 1 <= DEPTH);
      if (ok) begin m_occ += size + 1; m_mode = M_WR; end
    end else begin
      ok = (m_mode == M_HELD) && (m_occ >= size + 1);
      if (ok) begin m_occ -= size + 1; if (m_occ == 0) m_mode = M_FREE; end
    end
    exp_q.push_back(!ok ? E_ERR : (wr ? (E_STORE_TX | E_ACK) : (E_GET_RX | E_ACK)));
    ahb_size = 2'(size);
    if (wr) ahb_wr_req = 1'b1; else ahb_rd_req = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 8) begin
      tick();
      k++;
      seen = ahb_ack || ahb_err;
    end
    if (!seen) check("ahb_handshake_timeout", 0, 1);
    tick();
    ahb_rd_req = 1'b0;
    ahb_wr_req = 1'b0;
    tick();
  endtask

  task automatic do_flush();
    ahb_flush = 1'b1;
    exp_q.push_back(E_CLEAR);
    tick();
    ahb_flush = 1'b0;
    m_occ = 0;
    m_ovf = 1'b0;
    m_mode = M_FREE;
    tick();
  endtask

  task automatic tx_drain(input int extra);
    int n;
    bit ok;
    tx_packet_start = 1'b1; tick(); tx_packet_start = 1'b0;
    m_mode = M_TX;
    tick();
    ahb_req(1'b1, 0, ok);
    n = m_occ;
    for (int i = 0; i < n + extra; i++) begin
      tx_byte_req = 1'b1;
      if (i < n) exp_q.push_back(E_GET_TX);
      tick();
      tx_byte_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    m_occ = 0;
    m_mode = M_FREE;
    repeat (5) tick();
  endtask

  task automatic read_out();
    bit ok;
    int guard;
    guard = 0;
    while (m_occ > 0 && guard < 100) begin
      ahb_req(1'b0, $urandom_range(0, 3), ok);
      guard++;
    end
    repeat (2) tick();
  endtask

  initial begin
    bit ok;
    int n, k;
    rst = 1'b1;
    rx_packet_start = 1'b0; rx_byte_valid = 1'b0; rx_packet_done = 1'b0; rx_packet_err = 1'b0;
    ahb_rd_req = 1'b0; ahb_wr_req = 1'b0; ahb_size = 2'd0; ahb_flush = 1'b0;
    tx_packet_start = 1'b0; tx_byte_req = 1'b0;
    m_occ = 0; m_mode = M_FREE; m_ovf = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // four-byte packet read back in one 4-byte access
    rx_packet(4, 1'b0, 1'b1);
    check("rx4_busy", int'(rx_busy), 1);
    check("rx4_occ", int'(buffer_occupancy), 4);
    ahb_req(1'b0, 3, ok);
    repeat (2) tick();
    check("rx4_idle_busy", int'(rx_busy), 0);
    check_drained("rx4_drained");

    // random packet lengths, random read sizes
    repeat (6) begin
      n = $urandom_range(0, 40);
      rx_packet(n, 1'($urandom_range(0, 1)), 1'b1);
      check("rxr_busy", int'(rx_busy), (m_occ > 0) ? 1 : 0);
      check("rxr_occ", int'(buffer_occupancy), m_occ);
      read_out();
      check("rxr_idle_busy", int'(rx_busy), 0);
      check_drained("rxr_drained");
    end

    // overrun: more than DEPTH bytes
    rx_packet(DEPTH + 1 + $urandom_range(0, 3), 1'b0, 1'b1);
    check("ovf_flag", int'(rx_overflow), int'(m_ovf));
    check("ovf_occ", int'(buffer_occupancy), DEPTH);
    rx_packet_start = 1'b1; tick(); rx_packet_start = 1'b0; tick();
    check("ovf_cleared", int'(rx_overflow), 0);
    check("ovf_still_busy", int'(rx_busy), 1);
    do_flush();
    check_all_zero("flush_after_ovf");
    check_drained("ovf_drained");

    // underrun: 3-byte read of 2 bytes rejected, 2-byte read accepted
    rx_packet(2, 1'b1, 1'b1);
    ahb_req(1'b0, 2, ok);
    check("underrun_occ", int'(buffer_occupancy), 2);
    ahb_req(1'b0, 1, ok);
    repeat (2) tick();
    check("underrun_idle", int'(rx_busy), 0);
    check_drained("underrun_drained");

    // fill with 16 four-byte writes, 17th rejected, then TX drains all
    repeat (16) ahb_req(1'b1, 3, ok);
    check("wr_reserved", int'(buffer_reserved), 1);
    ahb_req(1'b1, $urandom_range(0, 3), ok);
    check("wr_full_occ", int'(buffer_occupancy), DEPTH);
    tx_drain($urandom_range(0, 3));
    check("tx_released", int'(buffer_reserved), 0);
    check("tx_occ", int'(buffer_occupancy), 0);
    check_drained("tx_drained");

    // random write sizes until one does not fit
    k = 0;
    do begin
      ahb_req(1'b1, $urandom_range(0, 3), ok);
      k++;
    end while (ok && k < 80);
    check("wrr_occ", int'(buffer_occupancy), m_occ);
    tx_drain($urandom_range(0, 2));
    check("txr_released", int'(buffer_reserved), 0);
    check_drained("txr_drained");

    // flush at occupancy 10 mid-packet
    rx_packet_start = 1'b1; tick(); rx_packet_start = 1'b0;
    repeat (10) begin
      rx_byte_valid = 1'b1; exp_q.push_back(E_STORE_RX); m_occ++; tick(); rx_byte_valid = 1'b0;
    end
    tick();
    check("flush_pre_occ", int'(buffer_occupancy), 10);
    do_flush();
    check_all_zero("flush_next_cycle");
    check("flush_occ", int'(buffer_occupancy), 0);
    check_drained("flush_drained");

    // aborted packet
    rx_packet($urandom_range(1, 30), 1'b0, 1'b0);
    check("rxerr_busy", int'(rx_busy), 0);
    check("rxerr_occ", int'(buffer_occupancy), 0);
    check_drained("rxerr_drained");

    // reset in the middle of TX
    repeat ($urandom_range(4, 8)) ahb_req(1'b1, $urandom_range(0, 3), ok);
    tx_packet_start = 1'b1; tick(); tx_packet_start = 1'b0;
    m_mode = M_TX;
    tick();
    k = $urandom_range(1, m_occ - 1);
    repeat (k) begin
      tx_byte_req = 1'b1; exp_q.push_back(E_GET_TX); tick(); tx_byte_req = 1'b0;
    end
    repeat (3) tick();
    check("midtx_reserved", int'(buffer_reserved), 1);
    check_drained("midtx_drained");
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid_tx");
    rst = 1'b0;
    m_occ = 0; m_mode = M_FREE; m_ovf = 1'b0;
    tick();
    ahb_req(1'b0, 0, ok);
    rx_packet(3, 1'b1, 1'b1);
    check("post_rst_busy", int'(rx_busy), 1);
    ahb_req(1'b0, 2, ok);
    repeat (2) tick();
    check("post_rst_idle", int'(rx_busy), 0);
    check_drained("post_rst_drained");

    repeat (4) tick();
    check_drained("final_drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1);
  end

endmodule
